median_writeback: RTL and testbench
===================================

# median_writeback

Write-side counterpart of the median-filter window reader. Consumes the stream of median pixels produced by the sort stage and writes the filtered frame, in raster order, into a single-port result block RAM. Border pixels, for which no 3x3 window exists, are filled with a constant. The block produces its own addresses, enable and write strobe for the RAM port and signals frame completion.

## Interface

Parameters:
- IMG_W, 13, image width in pixels; must be at least 3.
- IMG_H, 13, image height in pixels; must be at least 3.
- BASE_ADDR, 0, RAM address of pixel (0,0); BASE_ADDR + IMG_W*IMG_H must not exceed 4096. Checked at elaboration.
- BORDER_VAL, 8'd0, value written at every border position.

Ports:
- clka  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  single-cycle frame start request; honoured only in IDLE or DONE.
- pix_valid  in  1  pix_data holds a median pixel.
- pix_data  in  8  median pixel value.
- pix_ready  out  1  block accepts pix_data this cycle.
- bram_ena  out  1  RAM enable; equal to bram_wea.
- bram_wea  out  1  RAM write strobe; registered.
- bram_addr  out  12  RAM address; registered.
- bram_dina  out  8  RAM write data; registered.
- busy  out  1  high in SCAN.
- done  out  1  high in DONE; held until the next start or reset.

## Operation

- States: IDLE, SCAN, DONE.
  - IDLE or DONE with start=1: go to SCAN, row=0, col=0, addr=BASE_ADDR.
  - SCAN to DONE after the position (IMG_H-1, IMG_W-1) is processed.
  - A start asserted in SCAN is ignored.
- Position (row,col) is a border position if row=0, row=IMG_H-1, col=0 or col=IMG_W-1. All other positions are interior.
- In SCAN, exactly one position is handled per processing step:
  - Border position: write BORDER_VAL unconditionally and advance. No stream data is consumed.
  - Interior position: pix_ready=1. If pix_valid=1, write pix_data and advance. If pix_valid=0, stall with no write.
- pix_ready is combinational: SCAN and interior position. It does not depend on pix_valid.
- Advancing: col increments. At col=IMG_W-1, col goes to 0 and row increments. addr increments by 1 every step; no multiplier is used.
- Address arithmetic is 12-bit unsigned. The parameter check guarantees the address never wraps.
- Every position is written exactly once per frame, in raster order. No interior pixel is skipped or duplicated.
- Interior pixel count is (IMG_W-2)*(IMG_H-2). Data beyond that count is never accepted, because pix_ready is 0 outside SCAN.

## Timing

- Reset (reset=0 at an edge): state=IDLE, row=col=0, bram_wea=bram_ena=0, bram_addr=0, bram_dina=0, busy=0, done=0, pix_ready=0.
- Reset during SCAN aborts the frame. bram_wea is 0 from the next cycle. The partial frame is not resumed; the next start restarts at BASE_ADDR.
- Write latency: the decision at cycle N (a border step, or a valid&&ready handshake) appears at cycle N+1 as bram_wea=1 with the matching bram_addr and bram_dina.
- bram_wea=0 in cycles with no step. bram_addr and bram_dina hold their last values.
- start sampled at edge E0: SCAN is active in cycle 1.
- With no stalls, positions occupy cycles 1 to IMG_W*IMG_H and the last write is presented in cycle IMG_W*IMG_H+1.
- done rises in the cycle after the last write is presented, so the final write is committed first. busy falls when done rises.
- start in DONE: done=0 and busy=1 in the next cycle.

## Structure

- Package median_pkg holds:
  - ADDR_W=12 and PIX_W=8, shared with the reader side.
  - The state enum {IDLE, SCAN, DONE}.
- Sub-module median_raster_counter:
  - Holds the row, col and addr counters, driven by an advance input.
  - Outputs is_border and is_last.
  - The writer FSM and the output registers sit in median_writeback.

## Test plan

Defaults IMG_W=IMG_H=13, BASE_ADDR=0, BORDER_VAL=0 unless stated.

- Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0 and pix_ready=0 throughout.
- Full frame, pix_valid=1, pix_data incrementing from 0:
  - addr 14 gets 0, addr 15 gets 1, addr 27 gets 11, addr 154 gets 120.
  - addrs 0-13, 26 and 155-168 get 0.
  - 169 writes in total; done first high 171 cycles after the start edge.
- Backpressure: pix_valid=0 for 3 cycles at position (1,1), then valid data 8'hAA -> no writes during the stall, and addr 14 is written once with 8'hAA.
- Abort: reset=0 after 50 writes, then start -> bram_wea=0 the cycle after reset, and the first new write goes to addr 0.
- Start during SCAN is ignored (write count stays 169). Start in DONE begins a second frame, and done drops one cycle later.
- BASE_ADDR=4000, IMG_W=IMG_H=8, BORDER_VAL=8'hFF:
  - first write to addr 4000 = 8'hFF, last write to addr 4063 = 8'hFF.
  - 36 interior writes; no address at or above 4064.

Source files
------------

// File: rtl/median_pkg.sv
// Constants and state type shared by the median filter reader and writer sides.
package median_pkg;

  localparam int ADDR_W = 12;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/median_writeback_if.sv
// Median pixel stream in, result RAM port out.
interface median_writeback_if;
  import median_pkg::*;

  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              bram_ena;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_dina;

  modport slave (
    input  pix_valid, pix_data,
    output pix_ready, bram_ena, bram_wea, bram_addr, bram_dina
  );

  modport master (
    output pix_valid, pix_data,
    input  pix_ready, bram_ena, bram_wea, bram_addr, bram_dina
  );

endinterface

// File: rtl/median_raster_counter.sv
// Raster position tracker: row/col plus a linear address that steps by one, so no multiplier.
module median_raster_counter
  import median_pkg::*;
#(
  parameter int IMG_W     = 13,
  parameter int IMG_H     = 13,
  parameter int BASE_ADDR = 0
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              is_border_o,
  output logic              is_last_o
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] row_q, col_q, addr_q;

  assign is_border_o = (row_q == '0) || (row_q == LAST_ROW) ||
                       (col_q == '0) || (col_q == LAST_COL);
  assign is_last_o   = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign addr_o      = addr_q;

  // The final position holds so the address can never step past the frame.
  always_ff @(posedge clka) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (clear_i) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= BASE;
    end else if (advance_i && !is_last_o) begin
      addr_q <= addr_q + 1'b1;
      if (col_q == LAST_COL) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/median_writeback.sv
// Writes the median-filtered frame to the result RAM in raster order, filling borders with a constant.
// state | meaning
// IDLE  | waiting for start
// SCAN  | one position per step; fin_q marks the trailing cycle after the last step
// DONE  | frame committed, held until start
module median_writeback
  import median_pkg::*;
#(
  parameter int               IMG_W      = 13,
  parameter int               IMG_H      = 13,
  parameter int               BASE_ADDR  = 0,
  parameter logic [PIX_W-1:0] BORDER_VAL = 8'd0
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  median_writeback_if.slave  wb
);

  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_dims
    $error("median_writeback: IMG_W and IMG_H must be at least 3");
  end
  if (BASE_ADDR + IMG_W * IMG_H > 2 ** ADDR_W) begin : g_bad_range
    $error("median_writeback: frame does not fit in the RAM address space");
  end

  state_e            state_q;
  logic              fin_q, wea_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  dina_q;

  logic [ADDR_W-1:0] pos_addr;
  logic              is_border, is_last;
  logic              scan_act, step, clear;
  logic [PIX_W-1:0]  dina_d;

  assign scan_act     = (state_q == SCAN) && !fin_q;
  assign wb.pix_ready = scan_act && !is_border;
  assign step         = scan_act && (is_border || wb.pix_valid);
  assign clear        = start && (state_q != SCAN);
  assign dina_d       = is_border ? BORDER_VAL : wb.pix_data;

  median_raster_counter #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .BASE_ADDR (BASE_ADDR)
  ) u_cnt (
    .clka        (clka),
    .reset       (reset),
    .clear_i     (clear),
    .advance_i   (step),
    .addr_o      (pos_addr),
    .is_border_o (is_border),
    .is_last_o   (is_last)
  );

  // The extra SCAN cycle after the last step lets the final write commit before done.
  always_ff @(posedge clka) begin
    if (!reset) begin
      state_q <= IDLE;
      fin_q   <= 1'b0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wea_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SCAN;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SCAN: begin
          if (fin_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (step) begin
            wea_q  <= 1'b1;
            addr_q <= pos_addr;
            dina_q <= dina_d;
            fin_q  <= is_last;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.bram_wea  = wea_q;
  assign wb.bram_ena  = wea_q;
  assign wb.bram_addr = addr_q;
  assign wb.bram_dina = dina_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_median_writeback.sv
// Directed bench: a 13x13 frame at base 0 and an 8x8 frame at base 4000 with border 8'hFF.
module tb_median_writeback;
  import median_pkg::*;

  logic clka;
  logic reset;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;

  median_writeback_if ifa ();
  median_writeback_if ifb ();

  median_writeback #(
    .IMG_W(13), .IMG_H(13), .BASE_ADDR(0), .BORDER_VAL(8'd0)
  ) dut_a (
    .clka(clka), .reset(reset), .start(start_a),
    .busy(busy_a), .done(done_a), .wb(ifa.slave)
  );

  median_writeback #(
    .IMG_W(8), .IMG_H(8), .BASE_ADDR(4000), .BORDER_VAL(8'hFF)
  ) dut_b (
    .clka(clka), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b), .wb(ifb.slave)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int tests = 0;
  int fails = 0;

  // Monitor for instance A: RAM image, per-address hit counts, first write.
  logic       clr_a = 1'b0;
  logic [7:0] mem_a [4096];
  int         hits_a [4096];
  int         wr_a = 0;
  int         ena_bad_a = 0;
  int         first_addr_a = -1;
  int         first_data_a = -1;

  always @(negedge clka) begin
    if (clr_a) begin
      wr_a = 0;
      ena_bad_a = 0;
      first_addr_a = -1;
      first_data_a = -1;
      for (int i = 0; i < 4096; i++) begin
        mem_a[i]  = 8'hEE;
        hits_a[i] = 0;
      end
    end else begin
      if (ifa.bram_ena !== ifa.bram_wea) ena_bad_a++;
      if (ifa.bram_wea === 1'b1) begin
        if (wr_a == 0) begin
          first_addr_a = int'(ifa.bram_addr);
          first_data_a = int'(ifa.bram_dina);
        end
        wr_a++;
        mem_a[ifa.bram_addr] = ifa.bram_dina;
        hits_a[ifa.bram_addr]++;
      end
    end
  end

  // Monitor for instance B.
  int wr_b = 0, int_b = 0, max_addr_b = 0;
  int first_addr_b = -1, first_data_b = -1, last_addr_b = -1, last_data_b = -1;

  always @(negedge clka) begin
    if (ifb.bram_wea === 1'b1) begin
      if (wr_b == 0) begin
        first_addr_b = int'(ifb.bram_addr);
        first_data_b = int'(ifb.bram_dina);
      end
      last_addr_b = int'(ifb.bram_addr);
      last_data_b = int'(ifb.bram_dina);
      if (int'(ifb.bram_addr) > max_addr_b) max_addr_b = int'(ifb.bram_addr);
      if (ifb.bram_dina == 8'h11) int_b++;
      wr_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon_a();
    clr_a = 1'b1;
    @(negedge clka);
    #1;
    clr_a = 1'b0;
  endtask

  task automatic pulse_start_a();
    @(negedge clka);
    start_a = 1'b1;
    @(posedge clka);
    #1;
    start_a = 1'b0;
  endtask

  int   k;
  int   bad;
  logic hs;

  initial begin
    reset = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    ifa.pix_valid = 1'b0;
    ifa.pix_data  = 8'h00;
    ifb.pix_valid = 1'b1;
    ifb.pix_data  = 8'h11;

    // Reset held with start asserted: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      @(posedge clka);
      #1;
      chk("reset_a", {ifa.bram_wea, ifa.bram_ena, ifa.bram_addr, ifa.bram_dina,
                      busy_a, done_a, ifa.pix_ready}, 32'd0);
      chk("reset_b", {ifb.bram_wea, ifb.bram_ena, ifb.bram_addr, ifb.bram_dina,
                      busy_b, done_b, ifb.pix_ready}, 32'd0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clka);
    reset = 1'b1;

    // Full frame, data counts up on each accepted pixel; a stray start mid-frame.
    clear_mon_a();
    ifa.pix_valid = 1'b1;
    ifa.pix_data  = 8'h00;
    pulse_start_a();
    chk("scan_busy", busy_a, 1);
    k = 0;
    while (!done_a && k < 400) begin
      @(negedge clka);
      hs = ifa.pix_valid && ifa.pix_ready;
      start_a = (k == 60);
      @(posedge clka);
      #1;
      start_a = 1'b0;
      k++;
      if (hs) ifa.pix_data = ifa.pix_data + 8'd1;
    end
    chk("done_cycle", k + 1, 171);
    chk("busy_fall", busy_a, 0);
    chk("wr_count", wr_a, 169);
    chk("mem14", mem_a[14], 8'd0);
    chk("mem15", mem_a[15], 8'd1);
    chk("mem27", mem_a[27], 8'd11);
    chk("mem154", mem_a[154], 8'd120);
    bad = 0;
    for (int a = 0; a < 169; a++) begin
      if ((a < 14 || a == 26 || a >= 155) && mem_a[a] !== 8'd0) bad++;
    end
    chk("border_zero", bad, 0);
    bad = 0;
    for (int a = 0; a < 4096; a++) begin
      if (hits_a[a] != ((a < 169) ? 1 : 0)) bad++;
    end
    chk("hit_once", bad, 0);
    chk("ena_eq_wea", ena_bad_a, 0);

    repeat (3) @(posedge clka);
    #1;
    chk("done_hold", done_a, 1);

    // Second frame from DONE, with a stall at the first interior position.
    clear_mon_a();
    ifa.pix_valid = 1'b0;
    pulse_start_a();
    chk("restart_done", done_a, 0);
    chk("restart_busy", busy_a, 1);
    k = 0;
    do begin
      @(negedge clka);
      #1;
      k++;
    end while (!ifa.pix_ready && k < 100);
    chk("bp_ready", ifa.pix_ready, 1);
    chk("bp_base", wr_a, 14);
    for (int s = 0; s < 3; s++) begin
      @(negedge clka);
      #1;
      chk("bp_stall", wr_a, 14);
    end
    ifa.pix_valid = 1'b1;
    ifa.pix_data  = 8'hAA;
    @(posedge clka);
    #1;
    ifa.pix_data = 8'h01;
    k = 0;
    while (!done_a && k < 400) begin
      @(posedge clka);
      #1;
      k++;
    end
    chk("bp_done", done_a, 1);
    chk("bp_mem14", mem_a[14], 8'hAA);
    chk("bp_hits14", hits_a[14], 1);
    chk("bp_count", wr_a, 169);

    // Abort by reset after 50 writes, then restart.
    clear_mon_a();
    ifa.pix_data = 8'h33;
    pulse_start_a();
    k = 0;
    while (wr_a < 50 && k < 400) begin
      @(negedge clka);
      #1;
      k++;
    end
    chk("abort_at50", wr_a, 50);
    reset = 1'b0;
    @(posedge clka);
    #1;
    chk("abort_wea", ifa.bram_wea, 0);
    chk("abort_flags", {busy_a, done_a}, 0);
    reset = 1'b1;
    clear_mon_a();
    pulse_start_a();
    k = 0;
    while (wr_a < 1 && k < 50) begin
      @(negedge clka);
      #1;
      k++;
    end
    chk("abort_first_addr", first_addr_a, 0);
    chk("abort_first_data", first_data_a, 0);

    // 8x8 frame near the top of the address space.
    @(negedge clka);
    start_b = 1'b1;
    @(posedge clka);
    #1;
    start_b = 1'b0;
    k = 0;
    while (!done_b && k < 300) begin
      @(posedge clka);
      #1;
      k++;
    end
    chk("b_done", done_b, 1);
    chk("b_first_addr", first_addr_b, 4000);
    chk("b_first_data", first_data_b, 8'hFF);
    chk("b_last_addr", last_addr_b, 4063);
    chk("b_last_data", last_data_b, 8'hFF);
    chk("b_writes", wr_b, 64);
    chk("b_interior", int_b, 36);
    chk("b_max_addr", max_addr_b, 4063);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
